// File: rtl/cache_pkg.sv
// Shared cache-subsystem types: line width default and arbiter encodings.
// Imported by the caches and the lower-memory arbiter.
package cache_pkg;

  localparam int S_LINE = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    SEL_I = 1'b0,
    SEL_D = 1'b1
  } arb_sel_t;

endpackage

// File: rtl/arb_watchdog.sv
// Saturating wait counter for a granted memory transaction.
// Flags expiry in the cycle the count sits at TIMEOUT-1 with no hit.
module arb_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic hit,
  output logic expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;
  logic         waiting;

  assign waiting = enable & ~hit;
  assign expired = waiting & (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (waiting && count != LAST) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing the line-wide memory port between
// the instruction and data caches, with protocol and timeout flags.
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter int s_line  = S_LINE,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [31:0]       i_address,
  input  logic [s_line-1:0] i_wdata,
  output logic [s_line-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_address,
  input  logic [s_line-1:0] d_wdata,
  output logic [s_line-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_address,
  output logic [s_line-1:0] mem_wdata,
  input  logic [s_line-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              err_protocol,
  output logic              err_timeout
);

  arb_state_t state;
  arb_sel_t   sel;
  logic       last_d;
  logic       i_req;
  logic       d_req;
  logic       i_both;
  logic       d_both;
  logic       granted;
  logic       expired;
  logic       proto_bad;

  assign i_req   = i_read | i_write;
  assign d_req   = d_read | d_write;
  assign i_both  = i_read & i_write;
  assign d_both  = d_read & d_write;
  assign granted = (state != IDLE);
  assign sel     = (state == GRANT_D) ? SEL_D : SEL_I;

  // In IDLE any requester is checked; once granted, only the owner.
  assign proto_bad =
    ((state == IDLE)    & (i_both | d_both)) |
    ((state == GRANT_I) & i_both) |
    ((state == GRANT_D) & d_both);

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (~granted),
    .enable (granted),
    .hit    (mem_resp),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_d       <= 1'b0;
      err_protocol <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      if (proto_bad) err_protocol <= 1'b1;
      if (expired)   err_timeout  <= 1'b1;
      unique case (state)
        IDLE: begin
          if (i_req && (!d_req || last_d)) begin
            state  <= GRANT_I;
            last_d <= 1'b0;
          end else if (d_req) begin
            state  <= GRANT_D;
            last_d <= 1'b1;
          end
        end
        GRANT_I, GRANT_D: begin
          if (mem_resp || expired) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write-back wins when a requester raises both strobes.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    i_resp      = 1'b0;
    d_resp      = 1'b0;
    i_rdata     = '0;
    d_rdata     = '0;
    if (granted) begin
      i_rdata = mem_rdata;
      d_rdata = mem_rdata;
      unique case (sel)
        SEL_I: begin
          mem_write   = i_write;
          mem_read    = i_read & ~i_write;
          mem_address = i_address;
          mem_wdata   = i_wdata;
          i_resp      = mem_resp;
        end
        SEL_D: begin
          mem_write   = d_write;
          mem_read    = d_read & ~d_write;
          mem_address = d_address;
          mem_wdata   = d_wdata;
          d_resp      = mem_resp;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios plus random traffic
// compared each cycle against a transaction-level ownership model.
module tb_cache_mem_arbiter;

  localparam int LW  = 64;
  localparam int TMO = 8;

  logic          clk;
  logic          rst;
  logic          i_read, i_write, d_read, d_write;
  logic [31:0]   i_address, d_address;
  logic [LW-1:0] i_wdata, d_wdata, i_rdata, d_rdata;
  logic          i_resp, d_resp;
  logic          mem_read, mem_write, mem_resp;
  logic [31:0]   mem_address;
  logic [LW-1:0] mem_wdata, mem_rdata;
  logic          err_protocol, err_timeout;

  int checks;
  int failures;

  // Model: who owns memory (0 none, 1 icache, 2 dcache), who went last,
  // how many granted cycles have elapsed, and the sticky flags.
  int own;
  bit last_was_d;
  int waited;
  bit e_proto;
  bit e_to;
  bit i_got;
  bit d_got;

  cache_mem_arbiter #(
    .s_line (LW),
    .TIMEOUT(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_read      (i_read),
    .i_write     (i_write),
    .i_address   (i_address),
    .i_wdata     (i_wdata),
    .i_rdata     (i_rdata),
    .i_resp      (i_resp),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_address   (d_address),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_resp      (d_resp),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .err_protocol(err_protocol),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Compare one cycle at the falling edge, advance the model, step.
  task automatic tick();
    logic          er, ew, eri, erd;
    logic [31:0]   ea;
    logic [LW-1:0] ewd, erdat;
    bit            ireq, dreq;
    @(negedge clk);
    er = 0; ew = 0; eri = 0; erd = 0; ea = '0; ewd = '0; erdat = '0;
    if (own == 1) begin
      ew = i_write; er = i_read && !i_write;
      ea = i_address; ewd = i_wdata; eri = mem_resp; erdat = mem_rdata;
    end else if (own == 2) begin
      ew = d_write; er = d_read && !d_write;
      ea = d_address; ewd = d_wdata; erd = mem_resp; erdat = mem_rdata;
    end
    check("mem_read",  64'(mem_read),     64'(er));
    check("mem_write", 64'(mem_write),    64'(ew));
    check("mem_addr",  64'(mem_address),  64'(ea));
    check("mem_wdata", 64'(mem_wdata),    64'(ewd));
    check("i_resp",    64'(i_resp),       64'(eri));
    check("d_resp",    64'(d_resp),       64'(erd));
    check("i_rdata",   64'(i_rdata),      64'(erdat));
    check("d_rdata",   64'(d_rdata),      64'(erdat));
    check("err_proto", 64'(err_protocol), 64'(e_proto));
    check("err_tmo",   64'(err_timeout),  64'(e_to));
    i_got = i_resp;
    d_got = d_resp;
    ireq = i_read || i_write;
    dreq = d_read || d_write;
    if (rst) begin
      own = 0; last_was_d = 0; waited = 0; e_proto = 0; e_to = 0;
    end else begin
      if ((own == 0 && ((i_read && i_write) || (d_read && d_write))) ||
          (own == 1 && i_read && i_write) ||
          (own == 2 && d_read && d_write))
        e_proto = 1;
      if (own == 0) begin
        if (ireq && dreq) own = last_was_d ? 1 : 2;
        else if (ireq)    own = 1;
        else if (dreq)    own = 2;
        if (own != 0) begin
          last_was_d = (own == 2);
          waited = 0;
        end
      end else if (mem_resp) begin
        own = 0;
      end else begin
        waited++;
        if (waited == TMO) begin
          e_to = 1;
          own = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_read = 0; i_write = 0; i_address = '0; i_wdata = '0;
    d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
    mem_resp = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    tick();
    rst = 0;
  endtask

  task automatic drive_random();
    rst = ($urandom_range(0, 149) == 0);
    if (i_got) begin
      i_read = 0; i_write = 0;
    end else if (!(i_read || i_write) && $urandom_range(0, 2) == 0) begin
      i_write = 1'($urandom_range(0, 1));
      i_read = !i_write;
      i_address = $urandom & 32'hFFFF_FFE0;
      i_wdata = {$urandom, $urandom};
    end
    if (d_got) begin
      d_read = 0; d_write = 0;
    end else if (!(d_read || d_write) && $urandom_range(0, 2) == 0) begin
      d_write = 1'($urandom_range(0, 1));
      d_read = !d_write;
      d_address = $urandom & 32'hFFFF_FFE0;
      d_wdata = {$urandom, $urandom};
    end
    mem_resp = ($urandom_range(0, 2) == 0);
    mem_rdata = {$urandom, $urandom};
  endtask

  initial begin
    checks = 0; failures = 0;
    own = 0; last_was_d = 0; waited = 0; e_proto = 0; e_to = 0;
    i_got = 0; d_got = 0;
    rst = 1;
    clear_inputs();
    @(posedge clk);
    #1;
    do_reset();

    // I-only read, memory answers on the third granted cycle
    i_read = 1; i_address = 32'h0000_1000;
    tick(); #1;
    check("s1_rd", 64'(mem_read), 64'(1));
    check("s1_adr", 64'(mem_address), 64'h1000);
    tick(); tick();
    mem_resp = 1; mem_rdata = 64'hA5A5_0123_4567_5A5A; #1;
    check("s1_resp", 64'(i_resp), 64'(1));
    check("s1_line", 64'(i_rdata), 64'hA5A5_0123_4567_5A5A);
    check("s1_dq", 64'(d_resp), 64'(0));
    tick();
    i_read = 0; mem_resp = 0;
    tick();

    // Tie from reset: D first, then I, then D again
    do_reset();
    i_read = 1; i_address = 32'h2000;
    d_write = 1; d_address = 32'h3000; d_wdata = 64'hD0D0_1111_2222_D0D0;
    tick(); #1;
    check("s2_dwr", 64'(mem_write), 64'(1));
    check("s2_dwd", 64'(mem_wdata), 64'hD0D0_1111_2222_D0D0);
    mem_resp = 1; #1;
    check("s2_drsp", 64'(d_resp), 64'(1));
    check("s2_iq", 64'(i_resp), 64'(0));
    tick();
    d_write = 0; mem_resp = 0; #1;
    check("s2_gap", 64'(mem_read), 64'(0));
    tick(); #1;
    check("s2_ird", 64'(mem_read), 64'(1));
    check("s2_iadr", 64'(mem_address), 64'h2000);
    d_read = 1; d_address = 32'h3400; mem_resp = 1;
    tick();
    i_address = 32'h2400; mem_resp = 0;
    tick(); #1;
    check("s2_tie2", 64'(mem_address), 64'h3400);
    mem_resp = 1;
    tick();
    d_read = 0; mem_resp = 0;
    tick(); tick();
    mem_resp = 1;
    tick();
    i_read = 0; mem_resp = 0;
    tick();

    // D held off while I is in flight
    do_reset();
    i_read = 1; i_address = 32'h4000;
    tick();
    d_read = 1; d_address = 32'h5000;
    tick(); tick(); #1;
    check("s3_hold", 64'(mem_address), 64'h4000);
    mem_resp = 1;
    tick();
    i_read = 0; mem_resp = 0; #1;
    check("s3_idle", 64'(mem_read), 64'(0));
    tick(); #1;
    check("s3_dgnt", 64'(mem_read), 64'(1));
    check("s3_dadr", 64'(mem_address), 64'h5000);
    mem_resp = 1;
    tick();
    d_read = 0; mem_resp = 0;
    tick();

    // Watchdog: memory silent for eight granted cycles
    do_reset();
    i_read = 1; i_address = 32'h6000;
    tick();
    for (int k = 0; k < TMO; k++) tick();
    #1;
    check("s4_flag", 64'(err_timeout), 64'(1));
    check("s4_idle", 64'(mem_read), 64'(0));
    tick(); tick(); tick();
    i_read = 0;
    tick(); tick(); #1;
    check("s4_stky", 64'(err_timeout), 64'(1));
    do_reset(); #1;
    check("s4_clr", 64'(err_timeout), 64'(0));

    // Both strobes on the data side
    d_read = 1; d_write = 1; d_address = 32'h7000;
    tick(); #1;
    check("s5_err", 64'(err_protocol), 64'(1));
    check("s5_wr", 64'(mem_write), 64'(1));
    check("s5_rd", 64'(mem_read), 64'(0));
    mem_resp = 1;
    tick();
    d_read = 0; d_write = 0; mem_resp = 0;
    tick();

    // Reset mid-grant, then a tie resolves from reset priority
    do_reset();
    i_read = 1; i_address = 32'h8000;
    tick();
    rst = 1;
    tick();
    rst = 0; mem_resp = 1; #1;
    check("s6_rd", 64'(mem_read), 64'(0));
    check("s6_rsp", 64'(i_resp), 64'(0));
    mem_resp = 0; d_read = 1; d_address = 32'h9000;
    tick(); #1;
    check("s6_tie", 64'(mem_address), 64'h9000);
    mem_resp = 1;
    tick();
    d_read = 0; mem_resp = 0;
    tick();
    mem_resp = 1;
    tick();
    i_read = 0; mem_resp = 0;
    tick();

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      tick();
      drive_random();
    end
    rst = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Two-requester arbiter that shares the single line-wide lower memory port between the instruction cache and the data cache. It sits below both `cache` instances and above main memory. It serialises whole-line read and write-back transactions, using round-robin priority on simultaneous requests. A watchdog flags transactions that memory never acknowledges.

## Interface
Parameters:
- `s_line`, 256, line width in bits; sets the width of the rdata and wdata ports.
- `TIMEOUT`, 1024, cycles a granted transaction may wait for `mem_resp` before `err_timeout` sets.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_read`, `i_write`  in  1 each  instruction-cache request strobes; held until `i_resp`.
- `i_address`  in  32  line address; stable while a request is held.
- `i_wdata`  in  s_line  write-back line.
- `i_rdata`  out  s_line  fill line.
- `i_resp`  out  1  transaction-complete pulse.
- `d_read`, `d_write`, `d_address`, `d_wdata`, `d_rdata`, `d_resp`: same as the `i_*` ports, for the data cache.
- `mem_read`, `mem_write`  out  1 each  strobes to memory.
- `mem_address`  out  32  address to memory.
- `mem_wdata`  out  s_line  write data to memory.
- `mem_rdata`  in  s_line  read data from memory.
- `mem_resp`  in  1  memory-complete pulse.
- `err_protocol`  out  1  sticky; a requester raised read and write together.
- `err_timeout`  out  1  sticky; watchdog expired.

## Operation
- FSM states `IDLE`, `GRANT_I`, `GRANT_D`.
- `IDLE`:
  - Only the instruction cache requests → `GRANT_I`.
  - Only the data cache requests → `GRANT_D`.
  - Both request → grant the side that was not served last (register `last_d`), then update `last_d`.
  - No request → stay in `IDLE`.
- `GRANT_x`:
  - Drive `mem_read`/`mem_write` from the granted side's strobes.
  - Drive `mem_address`/`mem_wdata` from the granted side.
  - Route `mem_resp` to `x_resp` combinationally; the other side's resp stays 0.
  - On `mem_resp` → `IDLE`.
  - Requests from the other side are held off; they are not dropped.
- `mem_rdata` is broadcast to both `i_rdata` and `d_rdata`. Each requester samples it only on its own resp.
- In `IDLE`, all `mem_*` outputs and both resps are 0. `mem_address` and `mem_wdata` are driven to 0 in `IDLE`.
- Protocol error:
  - Read and write high together on a requester while it is granted, or while it is requesting in `IDLE`, sets `err_protocol`.
  - The transaction proceeds as a write (write-back wins).
- Watchdog:
  - A counter clears on entry to any `GRANT_x` and increments each granted cycle without `mem_resp`.
  - Reaching `TIMEOUT-1` sets `err_timeout` and forces a return to `IDLE` with no resp issued.
  - Counter width is `$clog2(TIMEOUT)`; the counter saturates and does not wrap.
- Error flags clear only on `rst`.

## Timing
- Reset values:
  - State `IDLE`, `last_d`=0 (so a tie right after reset grants D), counter 0.
  - All outputs 0, including both error flags.
- Grant latency: a request sampled in `IDLE` at edge N puts `mem_read`/`mem_write` high during cycle N+1.
- Response path: `mem_resp` to `x_resp` has zero cycles of latency (combinational).
- The FSM is back in `IDLE` for the cycle after `mem_resp`. Back-to-back grants are therefore separated by one `IDLE` cycle. This gives the served cache one edge to drop its strobe.
- Minimum transaction occupancy is 2 cycles (grant plus resp-in-same-cycle-as-grant is allowed if memory answers at once).
- `rst` asserted mid-transaction returns to `IDLE` at that edge; strobes are low the next cycle and no resp is issued.
- `mem_resp` while in `IDLE` is ignored; no resp is forwarded.

## Structure
- Shared package `cache_pkg`:
  - `arb_state_t` enum (`IDLE`, `GRANT_I`, `GRANT_D`).
  - `arb_sel_t` (`SEL_I`, `SEL_D`).
  - The `s_line` default as a localparam used by both `cache` and this block.
- Sub-module `arb_watchdog`, parameterised by `TIMEOUT`:
  - Inputs: `clk`, `rst`, `clear`, `enable`, `hit` (`mem_resp`).
  - Output: `expired`.
  - Contains the saturating counter.
- Output muxing is combinational on the registered state; no data registers are needed.

## Test plan
- I-only read at address 0x0000_1000, memory responds 3 cycles after grant:
  - `mem_read`=1 from cycle 1 with `mem_address`=0x1000.
  - `i_resp` pulses with the `mem_rdata` line.
  - `d_resp` stays 0.
- I read and D write both asserted from reset:
  - D is granted first (write data reaches `mem_wdata`).
  - After its resp and one `IDLE` cycle, I is granted.
  - A second tie then grants D (round-robin alternates).
- D read held while an I transaction is in flight:
  - `d_*` sees no resp and no `mem_read` until I completes.
  - D is granted exactly 2 cycles after `i_resp`.
- Watchdog with `TIMEOUT`=8, memory never responds:
  - `err_timeout` rises after 8 granted cycles and the FSM returns to `IDLE`.
  - No resp is issued; the flag persists until `rst`.
- `d_read`=`d_write`=1:
  - `err_protocol` sets and `mem_write`=1, `mem_read`=0.
- `rst` pulsed during `GRANT_I`:
  - Next cycle all outputs are 0; later requests are arbitrated from the reset priority.
